// File: rtl/mux_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter_pkg
// Shared constants for the time-shared 4-way mux arbiter:
//   - FSM state encodings (IDLE / GRANT)
//   - requester index constants (A..D map to mux select 0..3)
//   - default data width and grant quantum
//   - one-hot helper used to build grant vectors from a 2-bit index
// Optional feature macro used by the arbiter: MUX_ARB_QUANTUM_EN
// ---------------------------------------------------------------------------
package mux_share_arbiter_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_GRANT = 1'b1;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_QUANTUM = 4;

    // Grant vectors are always the one-hot image of the owner index.
    function automatic logic [3:0] toOneHot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_share_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// index ptr and ascending modulo 4; the first request not masked by excl wins.
// Ports:
//   req    [3:0]  request per requester
//   ptr    [1:0]  index the search starts from
//   excl   [3:0]  requesters removed from the search
//   winner [1:0]  index of the first eligible requester (0 when none)
//   any           at least one eligible requester exists
// ---------------------------------------------------------------------------
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] excl,
    output logic [1:0] winner,
    output logic       any
);

    logic [3:0] eligible;
    logic [1:0] idx;

    assign eligible = req & ~excl;

    // Walk from the farthest offset back to ptr so the closest eligible
    // index after ptr is the last one written and therefore wins.
    always_comb begin
        winner = 2'd0;
        any    = 1'b0;
        idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (eligible[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter
// Round-robin arbiter/sequencer sharing one 4-way selection datapath between
// four requesters. One owner is granted at a time; the registered output
// nibble f carries the owner's data one cycle behind the grant.
// Parameters:
//   WIDTH    data width of a..d and f
//   QUANTUM  max consecutive granted cycles per owner (1..15), only used
//            when MUX_ARB_QUANTUM_EN is defined
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req[3:0] request per requester
//   a,b,c,d  requester 0..3 data
//   gnt[3:0] registered one-hot grant
//   sel[1:0] registered owner index, drives the downstream mux
//   f        registered selected data
//   valid    f holds owner data this cycle
// Optional feature: `define MUX_ARB_QUANTUM_EN to preempt an owner after
// QUANTUM granted cycles when other requesters are waiting.
// ---------------------------------------------------------------------------
module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int QUANTUM = DEFAULT_QUANTUM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] f,
    output logic             valid
);

    if (QUANTUM < 1 || QUANTUM > 15) begin : gQuantumRange
        $error("mux_share_arbiter: QUANTUM must be in 1..15");
    end

    logic             state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             valid_q, valid_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [3:0]       pickExcl;
    logic [1:0]       pickWinner;
    logic             pickAny;
    logic [WIDTH-1:0] ownerData;
    logic             newGrant;

    // While granted the current owner is always excluded: on a normal
    // handover its req is already low, and on preemption it must not win.
    assign pickExcl = (state_q == STATE_GRANT) ? toOneHot(sel_q) : 4'b0000;

    rr_pick uPick (
        .req    (req),
        .ptr    (ptr_q),
        .excl   (pickExcl),
        .winner (pickWinner),
        .any    (pickAny)
    );

    always_comb begin
        ownerData = a;
        case (sel_q)
            REQ_A: ownerData = a;
            REQ_B: ownerData = b;
            REQ_C: ownerData = c;
            REQ_D: ownerData = d;
            default: ownerData = a;
        endcase
    end

`ifdef MUX_ARB_QUANTUM_EN
    logic [3:0] cnt_q, cnt_d;
    logic       quantumDone;

    assign quantumDone = (cnt_q == 4'(QUANTUM - 1));
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        f_d      = f_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        newGrant = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                if (pickAny) begin
                    newGrant = 1'b1;
                end
            end
            STATE_GRANT: begin
                f_d     = ownerData;
                valid_d = 1'b1;
                if (req[sel_q]) begin
`ifdef MUX_ARB_QUANTUM_EN
                    if (quantumDone && pickAny) begin
                        newGrant = 1'b1;
                    end
`endif
                end else if (pickAny) begin
                    newGrant = 1'b1;
                end else begin
                    state_d = STATE_IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        // sel is left untouched when going idle so the mux keeps its last path.
        if (newGrant) begin
            state_d = STATE_GRANT;
            gnt_d   = toOneHot(pickWinner);
            sel_d   = pickWinner;
            ptr_d   = pickWinner + 2'd1;
        end
    end

`ifdef MUX_ARB_QUANTUM_EN
    // The counter restarts on each new grant and also when a lone owner
    // exhausts its quantum, so it keeps re-arming while nobody else waits.
    always_comb begin
        cnt_d = cnt_q;
        if (newGrant || state_q == STATE_IDLE) begin
            cnt_d = 4'd0;
        end else if (quantumDone) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            f_q     <= '0;
            valid_q <= 1'b0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            f_q     <= f_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign f     = f_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_share_arbiter
// Directed testbench for mux_share_arbiter. Inputs change 1 time unit after
// each rising edge and outputs are sampled at the same point, so every value
// seen reflects the edge just taken. Compile with +define+MUX_ARB_QUANTUM_EN
// to exercise the quantum preemption variant.
// ---------------------------------------------------------------------------
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] f;
    logic       valid;

    int testCount = 0;
    int failCount = 0;

    mux_share_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .f     (f),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset across an edge with all inputs quiet, then release.
    task automatic doReset();
        req   = 4'b0000;
        a     = 4'h0;
        b     = 4'h0;
        c     = 4'h0;
        d     = 4'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Asynchronous reset asserted while requester 1 owns the channel.
    task automatic test_reset();
        doReset();
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        req = 4'b1110;
        tick();
        req = 4'b1111;
        tick();
        tick();
        testCount++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || f !== 4'h2 || valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_pre: gnt=%b sel=%0d f=%h valid=%b expected 0010/1/2/1", gnt, sel, f, valid);
        end
        rst_n = 1'b0;
        #1;
        testCount++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || f !== 4'h0 || valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_async: gnt=%b sel=%0d f=%h valid=%b expected all zero", gnt, sel, f, valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b0000;
    endtask

    // Single request: grant latency, data latency and pointer update.
    task automatic test_single_request();
        doReset();
        c   = 4'h7;
        req = 4'b0100;
        tick();
        testCount++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_grant: gnt=%b sel=%0d valid=%b expected 0100/2/0", gnt, sel, valid);
        end
        tick();
        testCount++;
        if (gnt !== 4'b0100 || f !== 4'h7 || valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL single_data: gnt=%b f=%h valid=%b expected 0100/7/1", gnt, f, valid);
        end
        req = 4'b0000;
        tick();
        tick();
        // ptr is now 3, so requester 3 beats 0 and 1.
        req = 4'b1011;
        tick();
        testCount++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            failCount++;
            $display("[TB] FAIL single_ptr: gnt=%b sel=%0d expected 1000/3", gnt, sel);
        end
    endtask

    // All four requesting; each owner drops after two cycles.
    task automatic test_round_robin();
        logic [3:0] data [4];
        int owner;
        int prev;
        doReset();
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        data[0] = 4'h1; data[1] = 4'h2; data[2] = 4'h3; data[3] = 4'h4;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            owner = i % 4;
            testCount++;
            if (gnt !== (4'b0001 << owner) || sel !== 2'(owner)) begin
                failCount++;
                $display("[TB] FAIL rr_grant%0d: gnt=%b sel=%0d expected owner %0d", i, gnt, sel, owner);
            end
            if (i > 0) begin
                prev = (i - 1) % 4;
                testCount++;
                if (valid !== 1'b1 || f !== data[prev]) begin
                    failCount++;
                    $display("[TB] FAIL rr_handover%0d: f=%h valid=%b expected %h/1", i, f, valid, data[prev]);
                end
            end
            tick();
            testCount++;
            if (gnt !== (4'b0001 << owner) || valid !== 1'b1 || f !== data[owner]) begin
                failCount++;
                $display("[TB] FAIL rr_hold%0d: gnt=%b f=%h valid=%b expected owner %0d data %h", i, gnt, f, valid, owner, data[owner]);
            end
            if (i < 4) begin
                req = 4'b1111 & ~(4'b0001 << owner);
                tick();
                req = 4'b1111;
            end
        end
    endtask

    // Owner 3 drops with nobody waiting: idle, then pointer wraps to 0.
    task automatic test_idle_wrap();
        doReset();
        d   = 4'h9;
        req = 4'b1000;
        tick();
        tick();
        req = 4'b0000;
        tick();
        testCount++;
        if (gnt !== 4'b0000 || sel !== 2'd3 || valid !== 1'b1 || f !== 4'h9) begin
            failCount++;
            $display("[TB] FAIL idle_enter: gnt=%b sel=%0d valid=%b f=%h expected 0000/3/1/9", gnt, sel, valid, f);
        end
        tick();
        testCount++;
        if (valid !== 1'b0 || gnt !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL idle_valid: valid=%b gnt=%b expected 0/0000", valid, gnt);
        end
        req = 4'b1001;
        tick();
        testCount++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL idle_wrap: gnt=%b sel=%0d expected 0001/0", gnt, sel);
        end
    endtask

    // Non-owner inputs toggle every cycle while requester 2 holds.
    task automatic test_non_owner_data();
        doReset();
        c   = 4'h5;
        req = 4'b0100;
        tick();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            b = 4'(15 - i);
            d = 4'(i);
            tick();
            testCount++;
            if (f !== 4'h5 || gnt !== 4'b0100 || valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL isolate%0d: f=%h gnt=%b valid=%b expected 5/0100/1", i, f, gnt, valid);
            end
        end
    endtask

`ifdef MUX_ARB_QUANTUM_EN
    // Two steady requesters alternate every 4 cycles; a lone one keeps it.
    task automatic test_quantum();
        logic [3:0] expGnt;
        doReset();
        req = 4'b0011;
        for (int n = 1; n <= 16; n++) begin
            tick();
            expGnt = (((n - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            testCount++;
            if (gnt !== expGnt) begin
                failCount++;
                $display("[TB] FAIL quantum_alt%0d: gnt=%b expected %b", n, gnt, expGnt);
            end
        end
        doReset();
        req = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            tick();
            testCount++;
            if (gnt !== 4'b0001) begin
                failCount++;
                $display("[TB] FAIL quantum_alone%0d: gnt=%b expected 0001", n, gnt);
            end
        end
    endtask
`else
    // Without a quantum an owner keeps the grant as long as it requests.
    task automatic test_quantum();
        doReset();
        req = 4'b0011;
        for (int n = 1; n <= 12; n++) begin
            tick();
            testCount++;
            if (gnt !== 4'b0001) begin
                failCount++;
                $display("[TB] FAIL hold_no_quantum%0d: gnt=%b expected 0001", n, gnt);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        req   = 4'b0000;
        a     = 4'h0;
        b     = 4'h0;
        c     = 4'h0;
        d     = 4'h0;
        #2;
        test_reset();
        test_single_request();
        test_round_robin();
        test_idle_wrap();
        test_non_owner_data();
        test_quantum();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
